// File: rtl/gameboy_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gameboy_pkg
// Brief   : Shared button, action and state encodings for the multi-player
//           game controller decoder.
// Revision: 1.0 - initial release
// ============================================================================
package gameboy_pkg;

  typedef enum logic [1:0] {
    BTN_FIGHT = 2'd0,
    BTN_REACT = 2'd1,
    BTN_A     = 2'd2,
    BTN_B     = 2'd3
  } button_t;

  typedef enum logic [2:0] {
    ACT_KICK    = 3'd0,
    ACT_PUNCH   = 3'd1,
    ACT_JUMP    = 3'd2,
    ACT_DUCK    = 3'd3,
    ACT_RUN     = 3'd4,
    ACT_SPECIAL = 3'd5,
    ACT_DODGE   = 3'd6
  } action_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIGHT = 2'd1,
    ST_REACT = 2'd2
  } state_t;

  localparam int c_MAX_PLAYERS = 8;
  localparam int c_MIN_TIMEOUT = 2;
  localparam int c_MAX_TIMEOUT = 255;

  // A and B are the only buttons that take part in combos.
  function automatic logic is_attack(button_t b);
    return (b == BTN_A) || (b == BTN_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gameboy_player.sv
`default_nettype none
// ============================================================================
// Module  : gameboy_player
// Brief   : One player channel: mode FSM, idle/gap counter, combo history.
// Revision: 1.0 - initial release
// ============================================================================
module gameboy_player
  import gameboy_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 16,
  parameter int COMBO_WINDOW = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] x,
  input  logic       x_valid,
  output logic [2:0] z,
  output logic       z_valid,
  output logic [1:0] mode
);

  localparam int                 c_CNT_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_WIN     = c_CNT_W'(COMBO_WINDOW);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

  state_t             r_state, w_state;
  logic [c_CNT_W-1:0] r_cnt,   w_cnt;
  logic [1:0]         r_hlen,  w_hlen;
  button_t            r_hold,  w_hold;
  button_t            r_hnew,  w_hnew;
  action_t            r_z,     w_z;
  logic               r_zv,    w_zv;

  button_t            w_btn;
  button_t            w_lead;
  button_t            w_tail;
  action_t            w_base;
  action_t            w_combo;
  logic [1:0]         w_hlen_eff;
  logic               w_combo_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hlen  <= 2'd0;
      r_hold  <= BTN_FIGHT;
      r_hnew  <= BTN_FIGHT;
      r_z     <= ACT_RUN;
      r_zv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_hlen  <= w_hlen;
      r_hold  <= w_hold;
      r_hnew  <= w_hnew;
      r_z     <= w_z;
      r_zv    <= w_zv;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_hlen      = r_hlen;
    w_hold      = r_hold;
    w_hnew      = r_hnew;
    w_z         = r_z;
    w_zv        = 1'b0;
    w_btn       = button_t'(x);

    // Combo is lead,lead,tail: A,A,B in FIGHT and B,B,A in REACT.
    w_lead      = (r_state == ST_REACT) ? BTN_B : BTN_A;
    w_tail      = (r_state == ST_REACT) ? BTN_A : BTN_B;
    w_combo     = (r_state == ST_REACT) ? ACT_DODGE : ACT_SPECIAL;
    if (r_state == ST_FIGHT) begin
      w_base = (w_btn == BTN_A) ? ACT_KICK : ACT_PUNCH;
    end else begin
      w_base = (w_btn == BTN_A) ? ACT_JUMP : ACT_DUCK;
    end

    // r_cnt counts cycles since the last press minus one, so gap <= window
    // is r_cnt < window; a stale history is treated as empty.
    w_hlen_eff  = (r_cnt < c_WIN) ? r_hlen : 2'd0;
    w_combo_hit = (w_hlen_eff == 2'd2) && (r_hold == w_lead) &&
                  (r_hnew == w_lead) && (w_btn == w_tail);

    if (x_valid) begin
      w_zv   = 1'b1;
      w_cnt  = '0;
      w_z    = ACT_RUN;
      w_hlen = 2'd0;
      if (r_state == ST_IDLE) begin
        if (w_btn == BTN_FIGHT) begin
          w_state = ST_FIGHT;
        end else if (w_btn == BTN_REACT) begin
          w_state = ST_REACT;
        end
      end else if (is_attack(w_btn)) begin
        if (w_combo_hit) begin
          w_z = w_combo;
        end else begin
          w_z    = w_base;
          w_hold = r_hnew;
          w_hnew = w_btn;
          w_hlen = (w_hlen_eff == 2'd0) ? 2'd1 : 2'd2;
        end
      end else if (((r_state == ST_FIGHT) && (w_btn == BTN_FIGHT)) ||
                   ((r_state == ST_REACT) && (w_btn == BTN_REACT))) begin
        w_state = ST_IDLE;
      end
    end else if (r_state != ST_IDLE) begin
      if (r_cnt >= c_TO_LAST) begin
        w_state = ST_IDLE;
        w_z     = ACT_RUN;
        w_zv    = 1'b1;
        w_cnt   = '0;
        w_hlen  = 2'd0;
      end else if (r_cnt != c_CNT_MAX) begin
        w_cnt = r_cnt + 1'b1;
      end
    end
  end

  assign z       = r_z;
  assign z_valid = r_zv;
  assign mode    = r_state;

endmodule
`default_nettype wire

// File: rtl/gameboy_multi.sv
`default_nettype none
// ============================================================================
// Module  : gameboy_multi
// Brief   : PLAYERS independent controller channels packed onto flat buses.
// Revision: 1.0 - initial release
// ============================================================================
module gameboy_multi
  import gameboy_pkg::*;
#(
  parameter int PLAYERS      = 2,
  parameter int IDLE_TIMEOUT = 16,
  parameter int COMBO_WINDOW = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2*PLAYERS-1:0]   x,
  input  logic [PLAYERS-1:0]     x_valid,
  output logic [3*PLAYERS-1:0]   z,
  output logic [PLAYERS-1:0]     z_valid,
  output logic [2*PLAYERS-1:0]   mode
);

  if ((PLAYERS < 1) || (PLAYERS > c_MAX_PLAYERS)) begin : g_bad_players
    $fatal(1, "gameboy_multi: PLAYERS=%0d outside 1..8", PLAYERS);
  end
  if ((IDLE_TIMEOUT < c_MIN_TIMEOUT) || (IDLE_TIMEOUT > c_MAX_TIMEOUT)) begin : g_bad_timeout
    $fatal(1, "gameboy_multi: IDLE_TIMEOUT=%0d outside 2..255", IDLE_TIMEOUT);
  end
  if ((COMBO_WINDOW < 1) || (COMBO_WINDOW > IDLE_TIMEOUT - 1)) begin : g_bad_window
    $fatal(1, "gameboy_multi: COMBO_WINDOW=%0d outside 1..IDLE_TIMEOUT-1", COMBO_WINDOW);
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    gameboy_player #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .COMBO_WINDOW (COMBO_WINDOW)
    ) u_player (
      .clock   (clock),
      .reset   (reset),
      .x       (x[2*p +: 2]),
      .x_valid (x_valid[p]),
      .z       (z[3*p +: 3]),
      .z_valid (z_valid[p]),
      .mode    (mode[2*p +: 2])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_gameboy_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_gameboy_multi
// Brief   : Scenario bench for gameboy_multi with a per-player action queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gameboy_multi;
  import gameboy_pkg::*;

  localparam int PLAYERS      = 4;
  localparam int IDLE_TIMEOUT = 16;
  localparam int COMBO_WINDOW = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [2*PLAYERS-1:0] x = '0;
  logic [PLAYERS-1:0]   x_valid = '0;
  logic [3*PLAYERS-1:0] z;
  logic [PLAYERS-1:0]   z_valid;
  logic [2*PLAYERS-1:0] mode;

  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q [PLAYERS][$];
  logic [2:0] mon_exp;

  always #5 clock = ~clock;

  gameboy_multi #(
    .PLAYERS      (PLAYERS),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .COMBO_WINDOW (COMBO_WINDOW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .x       (x),
    .x_valid (x_valid),
    .z       (z),
    .z_valid (z_valid),
    .mode    (mode)
  );

  // Every z_valid pulse must match the next queued action for that player.
  always @(negedge clock) begin
    if (!reset) begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (z_valid[p] === 1'b1) begin
          total++;
          if (exp_q[p].size() == 0) begin
            bad++;
            $display("FAIL unexpected_update p%0d: got z=%0d, required no pulse", p, z[3*p +: 3]);
          end else begin
            mon_exp = exp_q[p].pop_front();
            if (z[3*p +: 3] !== mon_exp) begin
              bad++;
              $display("FAIL action p%0d: got %0d, required %0d", p, z[3*p +: 3], mon_exp);
            end
          end
        end
      end
    end
  end

  function automatic action_t model_act(state_t s, button_t b);
    case (s)
      ST_FIGHT: return (b == BTN_A) ? ACT_KICK : (b == BTN_B) ? ACT_PUNCH : ACT_RUN;
      ST_REACT: return (b == BTN_A) ? ACT_JUMP : (b == BTN_B) ? ACT_DUCK : ACT_RUN;
      default:  return ACT_RUN;
    endcase
  endfunction

  function automatic state_t model_next(state_t s, button_t b);
    case (s)
      ST_IDLE:  return (b == BTN_FIGHT) ? ST_FIGHT : (b == BTN_REACT) ? ST_REACT : ST_IDLE;
      ST_FIGHT: return (b == BTN_FIGHT) ? ST_IDLE : ST_FIGHT;
      default:  return (b == BTN_REACT) ? ST_IDLE : ST_REACT;
    endcase
  endfunction

  // Tasks start and end 2 time units after a rising edge.
  task automatic press(input int p, input button_t b, input action_t a);
    x[2*p +: 2] = b;
    x_valid[p]  = 1'b1;
    exp_q[p].push_back(a);
    @(posedge clock); #2;
    x_valid[p]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #2;
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    for (int p = 0; p < PLAYERS; p++) begin
      total += 3;
      if (mode[2*p +: 2] !== ST_IDLE) begin
        bad++; $display("FAIL reset_mode p%0d: got %0d, required %0d", p, mode[2*p +: 2], ST_IDLE);
      end
      if (z[3*p +: 3] !== ACT_RUN) begin
        bad++; $display("FAIL reset_z p%0d: got %0d, required %0d", p, z[3*p +: 3], ACT_RUN);
      end
      if (z_valid[p] !== 1'b0) begin
        bad++; $display("FAIL reset_zvalid p%0d: got %0d, required 0", p, z_valid[p]);
      end
    end
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  task automatic test_decode;
    press(0, BTN_FIGHT, ACT_RUN);
    total += 2;
    if (z_valid[0] !== 1'b1) begin
      bad++; $display("FAIL decode_pulse0: got %0d, required 1", z_valid[0]);
    end
    if (mode[1:0] !== ST_FIGHT) begin
      bad++; $display("FAIL decode_mode0: got %0d, required %0d", mode[1:0], ST_FIGHT);
    end
    press(0, BTN_A, ACT_KICK);
    total++;
    if (z[2:0] !== ACT_KICK) begin
      bad++; $display("FAIL decode_kick: got %0d, required %0d", z[2:0], ACT_KICK);
    end
    idle(1);
    total += 4;
    if (z_valid[0] !== 1'b0) begin
      bad++; $display("FAIL decode_pulse_width: got %0d, required 0", z_valid[0]);
    end
    if (z[2:0] !== ACT_KICK) begin
      bad++; $display("FAIL decode_hold: got %0d, required %0d", z[2:0], ACT_KICK);
    end
    if (mode[3:2] !== ST_IDLE || z[5:3] !== ACT_RUN) begin
      bad++; $display("FAIL decode_p1: got mode=%0d z=%0d, required mode=0 z=4", mode[3:2], z[5:3]);
    end
    if (z_valid[1] !== 1'b0) begin
      bad++; $display("FAIL decode_p1_pulse: got %0d, required 0", z_valid[1]);
    end
    for (int p = 0; p < PLAYERS; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL decode_pending p%0d: got %0d outstanding, required 0", p, exp_q[p].size());
        exp_q[p].delete();
      end
    end
  endtask

  task automatic test_fight_combo;
    press(0, BTN_FIGHT, ACT_RUN);
    press(0, BTN_FIGHT, ACT_RUN);
    press(0, BTN_A, ACT_KICK);
    idle(1);
    press(0, BTN_A, ACT_KICK);
    idle(3);
    press(0, BTN_B, ACT_SPECIAL);
    total++;
    if (z[2:0] !== ACT_SPECIAL) begin
      bad++; $display("FAIL fight_special: got %0d, required %0d", z[2:0], ACT_SPECIAL);
    end
    press(0, BTN_A, ACT_KICK);
    idle(1);
    press(0, BTN_A, ACT_KICK);
    idle(4);
    press(0, BTN_B, ACT_PUNCH);
    total++;
    if (z[2:0] !== ACT_PUNCH) begin
      bad++; $display("FAIL fight_gap5: got %0d, required %0d", z[2:0], ACT_PUNCH);
    end
    idle(1);
    for (int p = 0; p < PLAYERS; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL fight_pending p%0d: got %0d outstanding, required 0", p, exp_q[p].size());
        exp_q[p].delete();
      end
    end
  endtask

  task automatic test_timeout;
    press(0, BTN_A, ACT_KICK);
    idle(IDLE_TIMEOUT - 1);
    total += 2;
    if (mode[1:0] !== ST_FIGHT) begin
      bad++; $display("FAIL timeout_early_mode: got %0d, required %0d", mode[1:0], ST_FIGHT);
    end
    if (z_valid[0] !== 1'b0) begin
      bad++; $display("FAIL timeout_early_pulse: got %0d, required 0", z_valid[0]);
    end
    exp_q[0].push_back(ACT_RUN);
    idle(1);
    total += 2;
    if (mode[1:0] !== ST_IDLE) begin
      bad++; $display("FAIL timeout_mode: got %0d, required %0d", mode[1:0], ST_IDLE);
    end
    if (z_valid[0] !== 1'b1) begin
      bad++; $display("FAIL timeout_pulse: got %0d, required 1", z_valid[0]);
    end
    idle(1);
    total++;
    if (z_valid[0] !== 1'b0) begin
      bad++; $display("FAIL timeout_single: got %0d, required 0", z_valid[0]);
    end
    press(0, BTN_FIGHT, ACT_RUN);
    idle(IDLE_TIMEOUT - 1);
    press(0, BTN_A, ACT_KICK);
    total++;
    if (mode[1:0] !== ST_FIGHT) begin
      bad++; $display("FAIL timeout_press_wins: got %0d, required %0d", mode[1:0], ST_FIGHT);
    end
    idle(IDLE_TIMEOUT - 1);
    total++;
    if (mode[1:0] !== ST_FIGHT) begin
      bad++; $display("FAIL timeout_restart: got %0d, required %0d", mode[1:0], ST_FIGHT);
    end
    exp_q[0].push_back(ACT_RUN);
    idle(1);
    total++;
    if (mode[1:0] !== ST_IDLE) begin
      bad++; $display("FAIL timeout_second: got %0d, required %0d", mode[1:0], ST_IDLE);
    end
    idle(3);
    for (int p = 0; p < PLAYERS; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL timeout_pending p%0d: got %0d outstanding, required 0", p, exp_q[p].size());
        exp_q[p].delete();
      end
    end
  endtask

  task automatic test_back_to_back;
    press(1, BTN_REACT, ACT_RUN);
    press(1, BTN_B, ACT_DUCK);
    press(1, BTN_B, ACT_DUCK);
    press(1, BTN_A, ACT_DODGE);
    press(1, BTN_A, ACT_JUMP);
    total++;
    if (mode[3:2] !== ST_REACT) begin
      bad++; $display("FAIL react_mode: got %0d, required %0d", mode[3:2], ST_REACT);
    end
    press(1, BTN_B, ACT_DUCK);
    idle(3);
    press(1, BTN_B, ACT_DUCK);
    idle(3);
    press(1, BTN_A, ACT_DODGE);
    press(1, BTN_REACT, ACT_RUN);
    total++;
    if (mode[3:2] !== ST_IDLE) begin
      bad++; $display("FAIL react_exit: got %0d, required %0d", mode[3:2], ST_IDLE);
    end
    idle(1);
    for (int p = 0; p < PLAYERS; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL react_pending p%0d: got %0d outstanding, required 0", p, exp_q[p].size());
        exp_q[p].delete();
      end
    end
  endtask

  task automatic test_async_reset;
    press(0, BTN_FIGHT, ACT_RUN);
    press(0, BTN_A, ACT_KICK);
    press(0, BTN_A, ACT_KICK);
    #1 reset = 1'b1;
    #1;
    total += 3;
    if (mode[1:0] !== ST_IDLE) begin
      bad++; $display("FAIL async_mode: got %0d, required %0d", mode[1:0], ST_IDLE);
    end
    if (z[2:0] !== ACT_RUN) begin
      bad++; $display("FAIL async_z: got %0d, required %0d", z[2:0], ACT_RUN);
    end
    if (z_valid[0] !== 1'b0) begin
      bad++; $display("FAIL async_zvalid: got %0d, required 0", z_valid[0]);
    end
    for (int p = 0; p < PLAYERS; p++) exp_q[p].delete();
    #3 reset = 1'b0;
    @(posedge clock); #2;
    press(0, BTN_FIGHT, ACT_RUN);
    press(0, BTN_B, ACT_PUNCH);
    total++;
    if (z[2:0] !== ACT_PUNCH) begin
      bad++; $display("FAIL async_after: got %0d, required %0d", z[2:0], ACT_PUNCH);
    end
    idle(1);
    for (int p = 0; p < PLAYERS; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL async_pending p%0d: got %0d outstanding, required 0", p, exp_q[p].size());
        exp_q[p].delete();
      end
    end
  endtask

  task automatic test_independence;
    button_t tbl [3][PLAYERS];
    state_t  ms  [PLAYERS];
    tbl[0] = '{BTN_FIGHT, BTN_REACT, BTN_A,     BTN_B};
    tbl[1] = '{BTN_A,     BTN_B,     BTN_FIGHT, BTN_REACT};
    tbl[2] = '{BTN_B,     BTN_A,     BTN_A,     BTN_B};
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    for (int p = 0; p < PLAYERS; p++) ms[p] = ST_IDLE;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < PLAYERS; p++) begin
        x[2*p +: 2] = tbl[r][p];
        exp_q[p].push_back(model_act(ms[p], tbl[r][p]));
        ms[p] = model_next(ms[p], tbl[r][p]);
      end
      x_valid = '1;
      @(posedge clock); #2;
      x_valid = '0;
      for (int p = 0; p < PLAYERS; p++) begin
        total++;
        if (mode[2*p +: 2] !== ms[p] || z_valid[p] !== 1'b1) begin
          bad++;
          $display("FAIL indep_r%0d_p%0d: got mode=%0d pulse=%0d, required mode=%0d pulse=1",
                   r, p, mode[2*p +: 2], z_valid[p], ms[p]);
        end
      end
    end
    idle(1);
    for (int p = 0; p < PLAYERS; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL indep_pending p%0d: got %0d outstanding, required 0", p, exp_q[p].size());
        exp_q[p].delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_fight_combo();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_independence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gameboy_multi.md
GAMEBOY_MULTI -- requirements
Module: gameboy_multi

Interface
REQ-001 The block SHALL take parameter PLAYERS, default 2: number of independent player channels, 1..8.
REQ-002 The block SHALL take parameter IDLE_TIMEOUT, default 16: consecutive press-free cycles in FIGHT/REACT before the channel falls back to IDLE, range 2..255.
REQ-003 The block SHALL take parameter COMBO_WINDOW, default 4: maximum gap in cycles between consecutive presses of a combo, range 1..IDLE_TIMEOUT-1.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port x, input, 2*PLAYERS bits: button code per player, slice p at [2p+1:2p]; Fight=0, React=1, A=2, B=3.
REQ-007 Port x_valid, input, PLAYERS bits: per-player press strobe; x slice p is sampled only when bit p is 1.
REQ-008 Port z, output, 3*PLAYERS bits: registered action per player, slice p at [3p+2:3p].
REQ-009 Port z_valid, output, PLAYERS bits: one-cycle pulse per player when z slice p is updated by a press or a timeout.
REQ-010 Port mode, output, 2*PLAYERS bits: current FSM state per player; IDLE=0, FIGHT=1, REACT=2.

Function
REQ-011 Action codes SHALL be Kick=0, Punch=1, Jump=2, Duck=3, Run=4, Special=5, Dodge=6; code 7 is never driven.
REQ-012 Each channel SHALL run its own FSM with no cross-channel coupling.
REQ-013 FSM states and transitions SHALL occur only on a valid press: IDLE: Fight->FIGHT, React->REACT, A/B stay. FIGHT: Fight->IDLE, others stay. REACT: React->IDLE, others stay.
REQ-014 Latency SHALL be 1 cycle: a press sampled at edge t drives z, z_valid and mode from edge t onward, visible in cycle t+1.
REQ-015 Action on a press SHALL be decided by the pre-press state. IDLE, any button: Run. FIGHT: Fight->Run, A->Kick, B->Punch. REACT: React->Run, A->Jump, B->Duck.
REQ-016 Press gap SHALL be the number of cycles since the previous valid press on that channel; back-to-back presses have gap 1.
REQ-017 In FIGHT, the sequence A,A,B with both gaps <= COMBO_WINDOW SHALL output Special instead of Punch.
REQ-018 In REACT, the sequence B,B,A with both gaps <= COMBO_WINDOW SHALL output Dodge instead of Jump.
REQ-019 Combo history SHALL be the last two A/B presses; it is cleared on a completed combo, any gap > COMBO_WINDOW, any Fight/React press, any state change and any timeout.
REQ-020 In FIGHT/REACT, after IDLE_TIMEOUT consecutive cycles with x_valid[p]=0, the channel SHALL enter IDLE, set z=Run and pulse z_valid once.
REQ-021 A valid press in the same cycle the timeout would fire SHALL win: the press is processed normally and the idle counter restarts.
REQ-022 The idle/gap counter SHALL be $clog2(IDLE_TIMEOUT+1) bits, SHALL saturate and never wrap, and SHALL hold at 0 while in IDLE.
REQ-023 z SHALL hold its last value between updates; z_valid SHALL be 0 when no update occurs.

Reset
REQ-024 While reset=1, every channel SHALL immediately (asynchronously) be forced to: mode=IDLE, z=Run, z_valid=0, counter=0, history empty.
REQ-025 A reset asserted during a partial combo SHALL discard it; the first press after reset deassertion is treated as the first press of a new sequence.

Structure
REQ-026 Package gameboy_pkg SHALL hold the button codes, action codes and the state enum; this block and its bench import it.
REQ-027 A single sub-module gameboy_player SHALL implement one channel (FSM, counter, history) and be instantiated PLAYERS times by a generate loop.
REQ-028 Parameter ranges SHALL be checked at elaboration; an out-of-range value is a fatal error.

Verification
REQ-029 Reset and decode: reset, then P0 press Fight, then A -> mode0=FIGHT, z0=Kick, z_valid0 pulses 1 cycle after each press; P1 stays IDLE/Run.
REQ-030 Fight combo: in FIGHT, P0 presses A,A,B at gaps 2,4 (COMBO_WINDOW=4) -> z0=Kick,Kick,Special; same sequence with gap 5 -> final z0=Punch.
REQ-031 React combo: in REACT, P1 presses B,B,A back-to-back -> z1=Duck,Duck,Dodge; the next A -> Jump (history cleared).
REQ-032 Timeout: in FIGHT, 16 idle cycles -> mode0=IDLE, z0=Run, single z_valid pulse; a press on cycle 16 -> no timeout, press decoded instead.
REQ-033 Async reset mid-combo: A,A, then a reset pulse between clock edges -> outputs at reset values before the next edge; after re-entering FIGHT, B -> Punch.
REQ-034 Independence: PLAYERS=4, all channels pressed in the same cycle with different codes -> each z slice matches the single-channel model.
